// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, func3 codes and FSM/owner encodings for the memory arbiter
package mem_arbiter_pkg;
  localparam int AddrWidth  = 32;
  localparam int DataWidth  = 32;
  localparam int Func3Width = 3;
  localparam logic [Func3Width-1:0] F3_LB  = 3'b000;
  localparam logic [Func3Width-1:0] F3_LH  = 3'b001;
  localparam logic [Func3Width-1:0] F3_LW  = 3'b010;
  localparam logic [Func3Width-1:0] F3_LBU = 3'b100;
  localparam logic [Func3Width-1:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_align_check.sv
// mem_align_check: flags misaligned or illegal accesses before they reach memory
module mem_align_check
  import mem_arbiter_pkg::*;
(
  input  logic [Func3Width-1:0] func3,
  input  logic [1:0]            addr,
  input  logic                  we,
  input  logic                  is_fetch,
  output logic                  err
);
  always_comb begin
    err = 1'b1;
    if (is_fetch) err = |addr;
    else
      unique case (func3)
        F3_LB:   err = 1'b0;
        F3_LH:   err = addr[0];
        F3_LW:   err = |addr;
        F3_LBU:  err = we;
        F3_LHU:  err = we | addr[0];
        default: err = 1'b1;
      endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto a fixed-latency memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [AddrWidth-1:0]  if_addr,
  output logic                  if_ready,
  output logic [DataWidth-1:0]  if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [Func3Width-1:0] d_func3,
  input  logic [AddrWidth-1:0]  d_addr,
  input  logic [DataWidth-1:0]  d_wdata,
  output logic                  d_ready,
  output logic                  d_err,
  output logic [DataWidth-1:0]  d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AddrWidth-1:0]  mem_addr,
  output logic [DataWidth-1:0]  mem_wdata,
  output logic [Func3Width-1:0] mem_func3,
  input  logic [DataWidth-1:0]  mem_rdata,
  output logic                  busy
);
  state_e                state_q, state_d;
  owner_e                owner_q;
  logic [1:0]            starve_q, starve_d;
  logic [2:0]            cnt_q;
  logic [AddrWidth-1:0]  addr_q, sel_addr;
  logic [DataWidth-1:0]  wdata_q, rdata_q;
  logic [Func3Width-1:0] func3_q, sel_func3;
  logic                  we_q, err_q, grant_data, any_req, sel_we, mis, done;
  assign any_req    = if_req | d_req;
  assign grant_data = d_req & ~(if_req & (starve_q == 2'd3));
  assign sel_addr   = grant_data ? d_addr : if_addr;
  assign sel_func3  = grant_data ? d_func3 : F3_LW;
  assign sel_we     = grant_data & d_we;
  assign starve_d   = ~grant_data ? 2'd0 : (if_req && starve_q != 2'd3) ? starve_q + 2'd1 : starve_q;
  mem_align_check u_align (
    .func3   (sel_func3),
    .addr    (sel_addr[1:0]),
    .we      (sel_we),
    .is_fetch(~grant_data),
    .err     (mis)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = ~any_req ? S_IDLE : mis ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (cnt_q == 3'd0) ? S_DONE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_FETCH;
      starve_q <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      func3_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_req) begin
        owner_q  <= grant_data ? OWN_DATA : OWN_FETCH;
        addr_q   <= sel_addr;
        func3_q  <= sel_func3;
        we_q     <= sel_we;
        wdata_q  <= grant_data ? d_wdata : '0;
        err_q    <= mis;
        rdata_q  <= '0;
        starve_q <= starve_d;
      end
      if (state_q == S_ISSUE) cnt_q <= 3'(MEM_LATENCY - 1);
      if (state_q == S_WAIT) begin
        cnt_q <= (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
        if (cnt_q == 3'd0) rdata_q <= we_q ? '0 : mem_rdata;
      end
    end
  end
  assign done      = state_q == S_DONE;
  assign busy      = state_q != S_IDLE;
  assign mem_en    = state_q == S_ISSUE;
  assign mem_we    = we_q & mem_en;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_func3 = func3_q;
  assign if_ready  = done & (owner_q == OWN_FETCH);
  assign d_ready   = done & (owner_q == OWN_DATA);
  assign if_err    = if_ready & err_q;
  assign d_err     = d_ready & err_q;
  assign if_rdata  = if_ready ? rdata_q : '0;
  assign d_rdata   = d_ready ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-timeline model
module tb_mem_arbiter;
  localparam int L = 2;
  localparam int N = 8192;
  logic clk = 1'b0, reset = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0, sw_req = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [2:0] d_func3 = 0;
  logic if_ready, if_err, d_ready, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_func3;
  logic a_ir, a_ie, a_dr, a_de, a_en, a_we, a_b, b_ir, b_ie, b_dr, b_de, b_en, b_we, b_b;
  logic [31:0] a_ird, a_drd, a_ma, a_mw, b_ird, b_drd, b_ma, b_mw;
  logic [2:0] a_f3, b_f3;
  int n_chk = 0, n_fail = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_err(if_err), .d_req(d_req), .d_we(d_we), .d_func3(d_func3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .busy(busy)
  );
  mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .if_req(sw_req), .if_addr(32'h0), .if_ready(a_ir),
    .if_rdata(a_ird), .if_err(a_ie), .d_req(1'b0), .d_we(1'b0), .d_func3(3'b0),
    .d_addr(32'h0), .d_wdata(32'h0), .d_ready(a_dr), .d_err(a_de), .d_rdata(a_drd),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_ma), .mem_wdata(a_mw),
    .mem_func3(a_f3), .mem_rdata(mem_rdata), .busy(a_b)
  );
  mem_arbiter #(.MEM_LATENCY(7)) u7 (
    .clk(clk), .reset(reset), .if_req(sw_req), .if_addr(32'h0), .if_ready(b_ir),
    .if_rdata(b_ird), .if_err(b_ie), .d_req(1'b0), .d_we(1'b0), .d_func3(3'b0),
    .d_addr(32'h0), .d_wdata(32'h0), .d_ready(b_dr), .d_err(b_de), .d_rdata(b_drd),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_ma), .mem_wdata(b_mw),
    .mem_func3(b_f3), .mem_rdata(mem_rdata), .busy(b_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic bit bad_access(bit fetch, logic [2:0] f3, bit we, logic [31:0] a);
    int bytes;
    if (fetch) return (a % 4) != 0;
    if (f3 == 3 || f3 >= 6 || (f3 >= 4 && we)) return 1'b1;
    bytes = 1 << (f3 % 4);
    return (a % bytes) != 0;
  endfunction
  bit e_en[N], e_we[N], e_ir[N], e_dr[N], e_err[N], e_busy[N], e_ld[N];
  logic [31:0] e_addr[N], e_wd[N], hist[N];
  logic [2:0] e_f3[N];
  int e_src[N];
  int free_at = 0, starve = 0, m_rc;
  bit model_on = 0, m_gd, m_bad, m_w;
  logic [31:0] m_a;
  logic [2:0] m_f;
  always @(negedge clk) if (model_on && cyc < N - 16) begin
    hist[cyc] = mem_rdata;
    chk("mem_en", mem_en, e_en[cyc]);
    if (e_en[cyc]) begin
      chk("mem_we", mem_we, e_we[cyc]);
      chk("mem_addr", mem_addr, e_addr[cyc]);
      chk("mem_func3", mem_func3, e_f3[cyc]);
      if (e_we[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
    end
    chk("if_ready", if_ready, e_ir[cyc]);
    chk("d_ready", d_ready, e_dr[cyc]);
    chk("if_err", if_err, e_ir[cyc] & e_err[cyc]);
    chk("d_err", d_err, e_dr[cyc] & e_err[cyc]);
    if (e_ir[cyc]) chk("if_rdata", if_rdata, e_ld[cyc] ? hist[e_src[cyc]] : 32'h0);
    if (e_dr[cyc]) chk("d_rdata", d_rdata, e_ld[cyc] ? hist[e_src[cyc]] : 32'h0);
    chk("busy", busy, e_busy[cyc]);
    if (reset) begin
      for (int i = cyc + 1; i <= cyc + 12; i++) begin
        e_en[i] = 0; e_we[i] = 0; e_ir[i] = 0; e_dr[i] = 0; e_err[i] = 0; e_busy[i] = 0; e_ld[i] = 0;
      end
      free_at = cyc + 1;
      starve = 0;
    end else if (cyc >= free_at && (if_req || d_req)) begin
      m_gd = d_req && !(if_req && starve == 3);
      m_a = m_gd ? d_addr : if_addr;
      m_f = m_gd ? d_func3 : 3'b010;
      m_w = m_gd && d_we;
      m_bad = bad_access(!m_gd, m_f, m_w, m_a);
      m_rc = m_bad ? cyc + 1 : cyc + 2 + L;
      e_ld[m_rc] = 0;
      if (!m_bad) begin
        e_en[cyc+1] = 1; e_we[cyc+1] = m_w; e_addr[cyc+1] = m_a; e_f3[cyc+1] = m_f; e_wd[cyc+1] = d_wdata;
        e_ld[m_rc] = !m_w;
        e_src[m_rc] = cyc + 1 + L;
      end
      if (m_gd) e_dr[m_rc] = 1; else e_ir[m_rc] = 1;
      e_err[m_rc] = m_bad;
      for (int i = cyc + 1; i <= m_rc; i++) e_busy[i] = 1;
      free_at = m_rc + 1;
      starve = !m_gd ? 0 : (if_req && starve < 3) ? starve + 1 : starve;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    mem_rdata = $urandom;
  endtask
  task automatic to_cycle(input int c);
    while (cyc < c) tick();
  endtask
  task automatic new_d;
    logic [31:0] r;
    r = $urandom;
    d_req = 1;
    d_we = 1'($urandom_range(0, 1));
    d_func3 = 3'($urandom_range(0, 7));
    d_addr = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
    d_wdata = $urandom;
  endtask
  task automatic new_i;
    logic [31:0] r;
    r = $urandom;
    if_req = 1;
    if_addr = ($urandom_range(0, 4) == 0) ? r : (r & 32'hFFFF_FFFC);
  endtask
  int c0, q1[$], q7[$];
  byte got[$];
  string pat;
  bit dr, ir;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    model_on = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_func3", mem_func3, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_if_ready", if_ready, 0);
    tick(); c0 = cyc;
    d_req = 1; d_we = 0; d_func3 = 3'b010; d_addr = 32'h100;
    @(negedge clk); chk("lw_en_c0", mem_en, 0);
    to_cycle(c0 + 1); @(negedge clk); chk("lw_en_c1", mem_en, 1); chk("lw_addr", mem_addr, 32'h100);
    to_cycle(c0 + 2); @(negedge clk); chk("lw_en_c2", mem_en, 0);
    to_cycle(c0 + 3); mem_rdata = 32'hDEADBEEF; @(negedge clk); chk("lw_ready_c3", d_ready, 0);
    to_cycle(c0 + 4); @(negedge clk); chk("lw_ready_c4", d_ready, 1); chk("lw_rdata", d_rdata, 32'hDEADBEEF);
    tick(); d_req = 0;
    tick(); c0 = cyc;
    d_req = 1; d_we = 1; d_func3 = 3'b010; d_addr = 32'h102;
    to_cycle(c0 + 1); @(negedge clk);
    chk("sw_mis_ready", d_ready, 1); chk("sw_mis_err", d_err, 1); chk("sw_mis_en", mem_en, 0);
    tick(); d_req = 0;
    tick(); c0 = cyc;
    d_req = 1; d_we = 1; d_func3 = 3'b001; d_addr = 32'h200; d_wdata = 32'h1234;
    to_cycle(c0 + 1); @(negedge clk);
    chk("sh_en", mem_en, 1); chk("sh_we", mem_we, 1); chk("sh_func3", mem_func3, 3'b001);
    chk("sh_addr", mem_addr, 32'h200); chk("sh_wdata", mem_wdata, 32'h1234);
    to_cycle(c0 + 4); @(negedge clk);
    chk("sh_ready", d_ready, 1); chk("sh_rdata", d_rdata, 0); chk("sh_err", d_err, 0);
    tick(); d_req = 0;
    tick();
    if_req = 1; if_addr = 32'h400;
    d_req = 1; d_we = 0; d_func3 = 3'b010; d_addr = 32'h10;
    for (int k = 0; k < 100 && got.size() < 8; k++) begin
      @(negedge clk);
      if (d_ready) got.push_back("D");
      if (if_ready) got.push_back("I");
      tick();
    end
    if_req = 0; d_req = 0;
    pat = "DDDIDDDI";
    chk("starve_grants", got.size(), 8);
    foreach (got[i]) chk($sformatf("starve_grant%0d", i), got[i], pat[i]);
    tick(); tick(); c0 = cyc;
    if_req = 1; if_addr = 32'h80;
    to_cycle(c0 + 2); reset = 1;
    to_cycle(c0 + 3); reset = 0; if_req = 0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0); chk("rstmid_en", mem_en, 0); chk("rstmid_addr", mem_addr, 0);
    for (int k = 0; k < 6; k++) begin
      tick(); @(negedge clk); chk("rstmid_no_ready", if_ready, 0);
    end
    tick(); c0 = cyc;
    if_req = 1; if_addr = 32'h84;
    to_cycle(c0 + 3); mem_rdata = 32'hCAFEF00D;
    to_cycle(c0 + 4); @(negedge clk);
    chk("refetch_ready", if_ready, 1); chk("refetch_rdata", if_rdata, 32'hCAFEF00D); chk("refetch_err", if_err, 0);
    tick(); if_req = 0;
    tick(); c0 = cyc; sw_req = 1;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (a_ir) q1.push_back(cyc);
      if (b_ir) q7.push_back(cyc);
      tick();
    end
    sw_req = 0;
    chk("lat1_count_ok", q1.size() >= 3, 1);
    chk("lat7_count_ok", q7.size() >= 3, 1);
    if (q1.size() > 0) chk("lat1_first", q1[0], c0 + 3);
    if (q7.size() > 0) chk("lat7_first", q7[0], c0 + 9);
    for (int i = 1; i < q1.size(); i++) chk("lat1_period", q1[i] - q1[i-1], 4);
    for (int i = 1; i < q7.size(); i++) chk("lat7_period", q7[i] - q7[i-1], 10);
    repeat (12) tick();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      dr = d_ready; ir = if_ready;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (d_req && dr) d_req = 0;
      if (if_req && ir) if_req = 0;
      if (!d_req && $urandom_range(0, 2) == 0) new_d();
      if (!if_req && $urandom_range(0, 2) == 0) new_i();
    end
    tick();
    reset = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      dr = d_ready; ir = if_ready;
      tick();
      if (dr) d_req = 0;
      if (ir) if_req = 0;
    end
    d_req = 0; if_req = 0;
    repeat (12) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
